md_scheduler: RTL and testbench

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler.sv | 125 ++++++++++++
 tb/tb_md_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Issue/retire scheduler for the multiply/divide unit and the HI/LO moves.
// An MD op occupies the unit for LAT cycles; any MD-class request in that window stalls.
module md_scheduler #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_abort,
    output logic        hilo_commit,
    output logic [1:0]  hilo_wr,
    output logic [31:0] hilo_data,
    output logic        rd_sel,
    output logic        stall,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // The counter is loaded with LAT-2: one cycle is spent in IDLE accepting, one in COMMIT.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 2);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  md_op_q, md_op_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            md_op_q <= 2'b00;
            md_a_q  <= 32'd0;
            md_b_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
            md_a_q  <= md_a_d;
            md_b_q  <= md_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_op_d     = md_op_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        md_start    = 1'b0;
        md_abort    = 1'b0;
        hilo_commit = 1'b0;
        hilo_wr     = 2'b00;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (!req_op[2]) begin
                        md_start = 1'b1;
                        md_op_d  = req_op[1:0];
                        md_a_d   = req_a;
                        md_b_d   = req_b;
                        cnt_d    = req_op[1] ? DIV_CNT : MUL_CNT;
                        state_d  = BUSY;
                    end else if (req_op[1] == 1'b0) begin
                        hilo_wr = req_op[0] ? 2'b10 : 2'b01;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    md_abort = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            COMMIT: begin
                // A flush here is too late: the op has already retired.
                hilo_commit = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted nothing may launch, abort or write.
        if (!reset) begin
            md_start    = 1'b0;
            md_abort    = 1'b0;
            hilo_commit = 1'b0;
            hilo_wr     = 2'b00;
        end
    end

    assign md_op     = md_op_q;
    assign md_a      = md_a_q;
    assign md_b      = md_b_q;
    assign hilo_data = req_a;
    assign rd_sel    = req_op[0];
    assign busy      = (state_q != IDLE);
    assign stall     = req_valid && (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: directed scenarios then random traffic, scored against
// a cycle-number model of the MD unit occupancy.
module tb_md_scheduler;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int W = 106;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_abort;
  logic        hilo_commit;
  logic [1:0]  hilo_wr;
  logic [31:0] hilo_data;
  logic        rd_sel;
  logic        stall;
  logic        busy;
  logic [1:0]  dbg_state;

  md_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .md_start(md_start),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_abort(md_abort),
    .hilo_commit(hilo_commit), .hilo_wr(hilo_wr), .hilo_data(hilo_data),
    .rd_sel(rd_sel), .stall(stall), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake: a request is presented with req_valid; it is taken in any cycle
  // where stall is low, otherwise the driver must present it again next cycle.

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // model: the unit is occupied from the cycle after acceptance through commit_at
  int          cyc = 0;
  int          commit_at = -1;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic        last_stall = 1'b0;

  function automatic logic [W-1:0] pack(input logic st, input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic ab, input logic cm,
      input logic [1:0] wr, input logic [31:0] dat, input logic rs, input logic stl,
      input logic bsy);
    return {st, op, a, b, ab, cm, wr, dat, rs, stl, bsy};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, g;
      e = exp_q.pop_front();
      g = pack(md_start, md_op, md_a, md_b, md_abort, hilo_commit, hilo_wr,
               hilo_data, rd_sel, stall, busy);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got start/op/a/b/abort/commit/wr/data/rdsel/stall/busy=%h required=%h",
                 $time, g, e);
      end
    end
  end

  // driver: apply one cycle of inputs, push the model's expectation, advance the model
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic rs);
    logic bsy, in_c, st, ab, cm, stl;
    logic [1:0] wr;
    req_valid = v; req_op = op; req_a = a; req_b = b; flush = fl; reset = rs;
    bsy  = (commit_at >= 0);
    in_c = bsy && (commit_at == cyc);
    stl  = v && bsy;
    cm   = rs && in_c;
    ab   = rs && bsy && !in_c && fl;
    st   = rs && !bsy && v && !fl && (op < 3'd4);
    wr   = 2'b00;
    if (rs && !bsy && v && !fl && op == 3'd4) wr = 2'b01;
    if (rs && !bsy && v && !fl && op == 3'd5) wr = 2'b10;
    exp_q.push_back(pack(st, m_op, m_a, m_b, ab, cm, wr, a, op[0], stl, bsy));
    if (!rs) begin
      commit_at = -1; m_op = 2'b00; m_a = 32'd0; m_b = 32'd0;
    end else begin
      if (in_c || ab) commit_at = -1;
      if (st) begin
        commit_at = cyc + ((op == 3'd2 || op == 3'd3) ? DIV_LAT : MUL_LAT);
        m_op = op[1:0]; m_a = a; m_b = b;
      end
    end
    last_stall = stl;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  // present a request and keep re-presenting it while it is stalled (bounded)
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int tries;
    tries = 0;
    step(1'b1, op, a, b, 1'b0, 1'b1);
    while (last_stall && tries < 40) begin
      step(1'b1, op, a, b, 1'b0, 1'b1);
      tries++;
    end
    if (last_stall) begin
      checks++; errors++;
      $display("FAIL retry_bound op=%0d still stalled after %0d cycles required=unstalled", op, tries);
    end
  endtask

  initial begin
    logic        pend;
    logic [2:0]  p_op;
    logic [31:0] p_a, p_b;
    logic        fl, rs;

    req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; flush = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;
    // reset state held for two cycles
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'h1, 32'h2, 1'b0, 1'b0);

    // mult alone: commit 5 cycles after acceptance
    step(1'b1, 3'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b1);
    idle(6);
    // divu followed by mflo held until it is let through
    step(1'b1, 3'd3, 32'h8000_0000, 32'h3, 1'b0, 1'b1);
    issue(3'd7, 32'h0, 32'h0);
    idle(1);
    // mthi / mtlo / mfhi from IDLE
    step(1'b1, 3'd4, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    step(1'b1, 3'd5, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    step(1'b1, 3'd6, 32'h0, 32'h0, 1'b0, 1'b1);
    // div then flush in its 4th busy cycle
    step(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b1);
    idle(3);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(12);
    // multu then a mult waiting behind it
    step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1);
    issue(3'd0, 32'h11, 32'h22);
    idle(7);
    // reset in the middle of a div, then a new mult
    step(1'b1, 3'd2, 32'd9, 32'd3, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'h5, 32'h6, 1'b0, 1'b1);
    idle(6);
    // flush on IDLE request drops it; flush in COMMIT is ignored
    step(1'b1, 3'd0, 32'h1, 32'h1, 1'b1, 1'b1);
    step(1'b1, 3'd4, 32'h1, 32'h1, 1'b1, 1'b1);
    step(1'b1, 3'd1, 32'h7, 32'h8, 1'b0, 1'b1);
    idle(4);
    step(1'b1, 3'd5, 32'h9, 32'h0, 1'b1, 1'b1);
    idle(2);

    // random traffic with retry of stalled requests
    pend = 1'b0; p_op = 3'd0; p_a = 32'd0; p_b = 32'd0;
    for (int i = 0; i < 800; i++) begin
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 59) != 0);
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        p_op = 3'($urandom_range(0, 7));
        p_a  = $urandom;
        p_b  = $urandom;
      end
      step(pend, p_op, p_a, p_b, fl, rs);
      if (!last_stall || fl || !rs) pend = 1'b0;
    end
    idle(DIV_LAT + 2);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
